// File: rtl/fpg8_ctrl_pkg.sv
// Shared constants and types for the FPG8 hardwired control sequencer.
// Opcodes, ALU operation codes (also used by the ALU block), GPR select codes,
// sequencer states and the bundle of control strobes driven each step.
package fpg8_ctrl_pkg;

  // Instruction opcodes, IR[15:12]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_MOV   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operation codes
  localparam logic [2:0] ALU_PASSY = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_NOTY  = 3'd5;

  // GPR select codes (4..7 unused)
  localparam logic [2:0] SEL_RD1 = 3'd0;
  localparam logic [2:0] SEL_RD2 = 3'd1;
  localparam logic [2:0] SEL_RS1 = 3'd2;
  localparam logic [2:0] SEL_RS2 = 3'd3;

  typedef enum logic [2:0] {
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_DECODE,
    ST_EXEC0,
    ST_EXEC1,
    ST_EXEC2,
    ST_HALT
  } state_e;

  // All strobes driven during one step
  typedef struct packed {
    logic [2:0] alu;
    logic       gpr_in;
    logic       gpr_out;
    logic [2:0] gpr_sel;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ram_rd;
    logic       ram_wr;
    logic       pc_out;
    logic       pc_inc;
    logic       y_in;
    logic       z_in;
    logic       z_out;
    logic       halted;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  // Two-operand register ops that go through Y/Z (MOV..OR)
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_OR);
  endfunction

  // Opcodes with no instruction assigned
  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_NOT) && (op < OP_HALT);
  endfunction

  // ALU code for the two-operand ops; anything else passes Y through
  function automatic logic [2:0] alu_of_op(input logic [3:0] op);
    logic [2:0] code;
    code = ALU_PASSY;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_PASSY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_counter.sv
// Memory access wait counter: loaded when a RAM step is entered, counts down while it is held.
// done_o marks the final wait cycle of the current step; done_next_o marks it for the coming step
// so the sequencer can register strobes (e.g. instr_done) that belong to that final cycle.
module mem_wait_counter
  import fpg8_ctrl_pkg::*;
#(
  parameter int RAM_WAIT = 1  // 1..7
) (
  input  logic one_shot_clock,
  input  logic reset,
  input  logic load_i,
  input  logic hold_i,
  output logic done_o,
  output logic done_next_o
);

  localparam logic [2:0] LOAD_VAL = 3'(RAM_WAIT - 1);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Remaining wait cycles after the current one; cleared whenever no RAM step is in progress
  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (hold_i) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Counter register
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == 3'd0);
  assign done_next_o = (cnt_d == 3'd0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired micro-step sequencer for the FPG8 single-bus datapath: fetch into IR, decode, execute.
// Strobes are registered decodes of the state being entered, so each is held for the whole step.
// NOP/illegal finish in the step after DECODE; HALT parks until reset.
module control_sequencer
  import fpg8_ctrl_pkg::*;
#(
  parameter int RAM_WAIT = 1  // cycles a RAM enable is held per access, 1..7
) (
  input  logic       one_shot_clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [2:0] ALU_control,
  output logic       GPR_in,
  output logic       GPR_out,
  output logic [2:0] GPR_select,
  output logic       IR_in,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       RAM_enable_read,
  output logic       RAM_enable_write,
  output logic       PC_out,
  output logic       PC_inc,
  output logic       Y_in,
  output logic       Z_in,
  output logic       Z_out,
  output logic       halted,
  output logic       illegal,
  output logic       instr_done
);

  state_e     state_q;
  state_e     state_d;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;
  logic [3:0] op_q;
  logic [3:0] op_cur;
  logic       mem_d;
  logic       wait_load;
  logic       wait_hold;
  logic       wait_done;
  logic       wait_done_next;

  // The opcode is sampled during DECODE and held for the execute steps
  assign op_cur = (state_q == ST_DECODE) ? opcode : op_q;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Leave FETCH0 only once its strobes have actually been issued (run was 1 on entry)
      ST_FETCH0: if (ctrl_q.pc_out) state_d = ST_FETCH1;
      ST_FETCH1: if (wait_done) state_d = ST_FETCH2;
      ST_FETCH2: state_d = ST_DECODE;
      ST_DECODE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC0;
      ST_EXEC0: begin
        if ((op_q == OP_NOP) || is_illegal(op_q)) state_d = ST_FETCH0;
        else                                     state_d = ST_EXEC1;
      end
      ST_EXEC1: if ((op_q != OP_LOAD) || wait_done) state_d = ST_EXEC2;
      ST_EXEC2: if ((op_q != OP_STORE) || wait_done) state_d = ST_FETCH0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH0;
    endcase
  end

  // RAM steps: instruction fetch, LOAD data read, STORE data write
  assign mem_d = (state_d == ST_FETCH1) ||
                 ((state_d == ST_EXEC1) && (op_cur == OP_LOAD)) ||
                 ((state_d == ST_EXEC2) && (op_cur == OP_STORE));
  assign wait_load = mem_d && (state_d != state_q);
  assign wait_hold = mem_d && (state_d == state_q);

  mem_wait_counter #(
    .RAM_WAIT(RAM_WAIT)
  ) u_wait (
    .one_shot_clock(one_shot_clock),
    .reset         (reset),
    .load_i        (wait_load),
    .hold_i        (wait_hold),
    .done_o        (wait_done),
    .done_next_o   (wait_done_next)
  );

  // Strobe decode for the step about to begin
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH0: begin
        if (run) begin
          ctrl_d.pc_out = 1'b1;
          ctrl_d.mar_in = 1'b1;
        end
      end
      ST_FETCH1: begin
        ctrl_d.ram_rd = 1'b1;
        ctrl_d.pc_inc = wait_load;  // first wait cycle only
      end
      ST_FETCH2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      ST_EXEC0: begin
        if (op_cur == OP_NOP) begin
          ctrl_d.instr_done = 1'b1;
        end else if (op_cur == OP_LOAD) begin
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RS1;
          ctrl_d.mar_in  = 1'b1;
        end else if (op_cur == OP_STORE) begin
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RD1;
          ctrl_d.mar_in  = 1'b1;
        end else if (is_alu_op(op_cur)) begin
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RS1;
          ctrl_d.y_in    = 1'b1;
        end else if (op_cur == OP_NOT) begin
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RD1;
          ctrl_d.y_in    = 1'b1;
        end else if (is_illegal(op_cur)) begin
          ctrl_d.illegal    = 1'b1;
          ctrl_d.instr_done = 1'b1;
        end
      end
      ST_EXEC1: begin
        if (op_cur == OP_LOAD) begin
          ctrl_d.ram_rd = 1'b1;
        end else if (op_cur == OP_STORE) begin
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RS1;
          ctrl_d.mdr_in  = 1'b1;
        end else if (is_alu_op(op_cur)) begin
          // MOV still drives Rd onto the bus; the ALU just passes Y
          ctrl_d.gpr_out = 1'b1;
          ctrl_d.gpr_sel = SEL_RD1;
          ctrl_d.alu     = alu_of_op(op_cur);
          ctrl_d.z_in    = 1'b1;
        end else if (op_cur == OP_NOT) begin
          ctrl_d.alu  = ALU_NOTY;
          ctrl_d.z_in = 1'b1;
        end
      end
      ST_EXEC2: begin
        if (op_cur == OP_LOAD) begin
          ctrl_d.mdr_out    = 1'b1;
          ctrl_d.gpr_in     = 1'b1;
          ctrl_d.gpr_sel    = SEL_RD1;
          ctrl_d.instr_done = 1'b1;
        end else if (op_cur == OP_STORE) begin
          ctrl_d.ram_wr     = 1'b1;
          ctrl_d.instr_done = wait_done_next;
        end else begin
          ctrl_d.z_out      = 1'b1;
          ctrl_d.gpr_in     = 1'b1;
          ctrl_d.gpr_sel    = SEL_RD1;
          ctrl_d.instr_done = 1'b1;
        end
      end
      ST_HALT: ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State, strobe and opcode registers
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      state_q <= ST_FETCH0;
      ctrl_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_cur;
    end
  end

  assign ALU_control      = ctrl_q.alu;
  assign GPR_in           = ctrl_q.gpr_in;
  assign GPR_out          = ctrl_q.gpr_out;
  assign GPR_select       = ctrl_q.gpr_sel;
  assign IR_in            = ctrl_q.ir_in;
  assign MAR_in           = ctrl_q.mar_in;
  assign MDR_in           = ctrl_q.mdr_in;
  assign MDR_out          = ctrl_q.mdr_out;
  assign RAM_enable_read  = ctrl_q.ram_rd;
  assign RAM_enable_write = ctrl_q.ram_wr;
  assign PC_out           = ctrl_q.pc_out;
  assign PC_inc           = ctrl_q.pc_inc;
  assign Y_in             = ctrl_q.y_in;
  assign Z_in             = ctrl_q.z_in;
  assign Z_out            = ctrl_q.z_out;
  assign halted           = ctrl_q.halted;
  assign illegal          = ctrl_q.illegal;
  assign instr_done       = ctrl_q.instr_done;

  // Single bus: never more than one driver in a step
  a_one_bus_driver : assert property (@(posedge one_shot_clock) disable iff (reset)
    $onehot0({GPR_out, MDR_out, PC_out, Z_out}));

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (RAM_WAIT 1 and 3) checked step by step
// against per-instruction strobe tables built from the instruction set description.
module tb_control_sequencer;

  localparam int W0 = 1;
  localparam int W1 = 3;

  typedef struct packed {
    logic [2:0] alu;
    logic       gpr_in;
    logic       gpr_out;
    logic [2:0] sel;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       rd;
    logic       wr;
    logic       pc_out;
    logic       pc_inc;
    logic       y_in;
    logic       z_in;
    logic       z_out;
    logic       halted;
    logic       illegal;
    logic       done;
  } step_t;
  typedef step_t      step_q_t[$];
  typedef logic [3:0] op_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_v [2];
  logic [3:0] op_v  [2];
  logic [2:0] alu_w [2];
  logic       gpr_in_w [2], gpr_out_w [2];
  logic [2:0] sel_w [2];
  logic       ir_in_w [2], mar_in_w [2], mdr_in_w [2], mdr_out_w [2];
  logic       rd_w [2], wr_w [2], pc_out_w [2], pc_inc_w [2];
  logic       y_in_w [2], z_in_w [2], z_out_w [2];
  logic       halted_w [2], illegal_w [2], done_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.RAM_WAIT(W0)) dut0 (
    .one_shot_clock(clk), .reset(reset), .run(run_v[0]), .opcode(op_v[0]),
    .ALU_control(alu_w[0]), .GPR_in(gpr_in_w[0]), .GPR_out(gpr_out_w[0]), .GPR_select(sel_w[0]),
    .IR_in(ir_in_w[0]), .MAR_in(mar_in_w[0]), .MDR_in(mdr_in_w[0]), .MDR_out(mdr_out_w[0]),
    .RAM_enable_read(rd_w[0]), .RAM_enable_write(wr_w[0]), .PC_out(pc_out_w[0]), .PC_inc(pc_inc_w[0]),
    .Y_in(y_in_w[0]), .Z_in(z_in_w[0]), .Z_out(z_out_w[0]),
    .halted(halted_w[0]), .illegal(illegal_w[0]), .instr_done(done_w[0])
  );

  control_sequencer #(.RAM_WAIT(W1)) dut1 (
    .one_shot_clock(clk), .reset(reset), .run(run_v[1]), .opcode(op_v[1]),
    .ALU_control(alu_w[1]), .GPR_in(gpr_in_w[1]), .GPR_out(gpr_out_w[1]), .GPR_select(sel_w[1]),
    .IR_in(ir_in_w[1]), .MAR_in(mar_in_w[1]), .MDR_in(mdr_in_w[1]), .MDR_out(mdr_out_w[1]),
    .RAM_enable_read(rd_w[1]), .RAM_enable_write(wr_w[1]), .PC_out(pc_out_w[1]), .PC_inc(pc_inc_w[1]),
    .Y_in(y_in_w[1]), .Z_in(z_in_w[1]), .Z_out(z_out_w[1]),
    .halted(halted_w[1]), .illegal(illegal_w[1]), .instr_done(done_w[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic step_t sample(input int k);
    step_t s;
    s.alu = alu_w[k];       s.gpr_in = gpr_in_w[k];   s.gpr_out = gpr_out_w[k];
    s.sel = sel_w[k];       s.ir_in = ir_in_w[k];     s.mar_in = mar_in_w[k];
    s.mdr_in = mdr_in_w[k]; s.mdr_out = mdr_out_w[k]; s.rd = rd_w[k];
    s.wr = wr_w[k];         s.pc_out = pc_out_w[k];   s.pc_inc = pc_inc_w[k];
    s.y_in = y_in_w[k];     s.z_in = z_in_w[k];       s.z_out = z_out_w[k];
    s.halted = halted_w[k]; s.illegal = illegal_w[k]; s.done = done_w[k];
    return s;
  endfunction

  // Expected strobes, one entry per step, for one instruction (fetch through last execute step).
  // For HALT only the fetch/decode steps are listed; the halted steps follow.
  function automatic step_q_t model(input logic [3:0] op, input int w);
    step_q_t q;
    step_t   s;
    q = {};
    s = '0; s.pc_out = 1'b1; s.mar_in = 1'b1; q.push_back(s);
    for (int i = 0; i < w; i++) begin
      s = '0; s.rd = 1'b1; s.pc_inc = (i == 0); q.push_back(s);
    end
    s = '0; s.mdr_out = 1'b1; s.ir_in = 1'b1; q.push_back(s);
    s = '0; q.push_back(s);
    case (op)
      4'h0: begin
        s = '0; s.done = 1'b1; q.push_back(s);
      end
      4'h1: begin
        s = '0; s.gpr_out = 1'b1; s.sel = 3'd2; s.mar_in = 1'b1; q.push_back(s);
        for (int i = 0; i < w; i++) begin
          s = '0; s.rd = 1'b1; q.push_back(s);
        end
        s = '0; s.mdr_out = 1'b1; s.gpr_in = 1'b1; s.done = 1'b1; q.push_back(s);
      end
      4'h2: begin
        s = '0; s.gpr_out = 1'b1; s.mar_in = 1'b1; q.push_back(s);
        s = '0; s.gpr_out = 1'b1; s.sel = 3'd2; s.mdr_in = 1'b1; q.push_back(s);
        for (int i = 0; i < w; i++) begin
          s = '0; s.wr = 1'b1; s.done = (i == w - 1); q.push_back(s);
        end
      end
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        s = '0; s.gpr_out = 1'b1; s.sel = 3'd2; s.y_in = 1'b1; q.push_back(s);
        s = '0; s.gpr_out = 1'b1; s.z_in = 1'b1;
        case (op)
          4'h3:    s.alu = 3'd0;
          4'h4:    s.alu = 3'd1;
          4'h5:    s.alu = 3'd2;
          4'h6:    s.alu = 3'd3;
          default: s.alu = 3'd4;
        endcase
        q.push_back(s);
        s = '0; s.z_out = 1'b1; s.gpr_in = 1'b1; s.done = 1'b1; q.push_back(s);
      end
      4'h8: begin
        s = '0; s.gpr_out = 1'b1; s.y_in = 1'b1; q.push_back(s);
        s = '0; s.alu = 3'd5; s.z_in = 1'b1; q.push_back(s);
        s = '0; s.z_out = 1'b1; s.gpr_in = 1'b1; s.done = 1'b1; q.push_back(s);
      end
      4'hF: begin
      end
      default: begin
        s = '0; s.illegal = 1'b1; s.done = 1'b1; q.push_back(s);
      end
    endcase
    return q;
  endfunction

  // Run a list of instructions back to back on instance k (run held high until the last one
  // starts), then confirm it parks in FETCH0 with all strobes low.
  task automatic do_seq(input int k, input op_q_t ops, input string tag);
    step_q_t q;
    step_q_t part;
    int      starts[$];
    step_t   got;
    q = {};
    foreach (ops[j]) begin
      starts.push_back(q.size());
      part = model(ops[j], wait_of(k));
      foreach (part[i]) q.push_back(part[i]);
    end
    op_v[k]  = ops[0];
    run_v[k] = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      got = sample(k);
      checks++;
      if (got !== q[i]) begin
        errors++;
        $display("FAIL %s dut%0d step %0d got %h want %h", tag, k, i, got, q[i]);
      end
      if (i == starts[starts.size()-1]) run_v[k] = 1'b0;
      for (int j = 1; j < starts.size(); j++)
        if (i + 1 == starts[j]) op_v[k] = ops[j];
    end
    @(posedge clk); #1;
    got = sample(k);
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s_park dut%0d got %h want 0", tag, k, got);
    end
  endtask

  task automatic run_both(input op_q_t ops, input string tag);
    fork
      do_seq(0, ops, tag);
      do_seq(1, ops, tag);
    join
  endtask

  // Assert reset for n cycles, expecting every strobe low during and after it
  task automatic apply_reset(input int n, input string tag);
    step_t got;
    reset = 1'b1;
    run_v[0] = 1'b0;
    run_v[1] = 1'b0;
    for (int c = 0; c < n + 1; c++) begin
      if (c == n) reset = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        got = sample(k);
        checks++;
        if (got !== '0) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d got %h want 0", tag, k, c, got);
        end
      end
    end
  endtask

  task automatic test_reset();
    op_v[0] = 4'h0;
    op_v[1] = 4'h0;
    apply_reset(2, "reset_init");
    // Start a LOAD on both and cut it short
    op_v[0] = 4'h1; op_v[1] = 4'h1;
    run_v[0] = 1'b1; run_v[1] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    apply_reset(2, "reset_mid_load");
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (halted_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_halted dut%0d got %b want 0", k, halted_w[k]);
      end
    end
  endtask

  task automatic test_add();
    op_q_t ops;
    ops = {};
    ops.push_back(4'h4);
    run_both(ops, "add");
  endtask

  task automatic test_load();
    op_q_t ops;
    ops = {};
    ops.push_back(4'h1);
    run_both(ops, "load");
  endtask

  task automatic test_store();
    op_q_t ops;
    ops = {};
    ops.push_back(4'h2);
    run_both(ops, "store");
  endtask

  task automatic test_illegal();
    op_q_t ops;
    step_t got;
    ops = {};
    ops.push_back(4'hB);
    run_both(ops, "illegal");
    // Stays parked with run low
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        got = sample(k);
        checks++;
        if (got !== '0) begin
          errors++;
          $display("FAIL park_hold dut%0d got %h want 0", k, got);
        end
      end
    end
  endtask

  task automatic halt_one(input int k);
    step_q_t q;
    step_t   got;
    step_t   hs;
    q = model(4'hF, wait_of(k));
    op_v[k]  = 4'hF;
    run_v[k] = 1'b1;
    foreach (q[i]) begin
      @(posedge clk); #1;
      got = sample(k);
      checks++;
      if (got !== q[i]) begin
        errors++;
        $display("FAIL halt_fetch dut%0d step %0d got %h want %h", k, i, got, q[i]);
      end
    end
    hs = '0;
    hs.halted = 1'b1;
    for (int c = 0; c < 20; c++) begin
      run_v[k] = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      got = sample(k);
      checks++;
      if (got !== hs) begin
        errors++;
        $display("FAIL halt_hold dut%0d cycle %0d got %h want %h", k, c, got, hs);
      end
    end
  endtask

  task automatic test_halt();
    fork
      halt_one(0);
      halt_one(1);
    join
    apply_reset(1, "halt_reset");
  endtask

  task automatic test_back_to_back();
    op_q_t ops;
    ops = {};
    ops.push_back(4'h3);
    ops.push_back(4'h2);
    ops.push_back(4'h1);
    ops.push_back(4'h8);
    ops.push_back(4'h0);
    ops.push_back(4'hE);
    ops.push_back(4'h7);
    run_both(ops, "b2b");
  endtask

  task automatic test_random();
    op_q_t ops;
    for (int r = 0; r < 6; r++) begin
      ops = {};
      for (int n = 0; n < 5; n++) ops.push_back(4'($urandom_range(14, 0)));
      run_both(ops, "random");
    end
  endtask

  initial begin
    run_v[0] = 1'b0;
    run_v[1] = 1'b0;
    op_v[0]  = 4'h0;
    op_v[1]  = 4'h0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_illegal();
    test_back_to_back();
    test_random();
    test_halt();
    test_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
